// File: rtl/rom_load_bridge_if.sv
// rom_load_bridge_if: ioctl download stream plus toggle-handshake memory write port
interface rom_load_bridge_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [DW-1:0] ioctl_dout;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we_req;
    logic          mem_we_ack;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_we_ack,
        input  ioctl_wait, mem_addr, mem_din, mem_we_req
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_we_ack,
        output ioctl_wait, mem_addr, mem_din, mem_we_req
    );
endinterface

// File: rtl/rom_load_bridge.sv
// rom_load_bridge: FIFO-buffered ioctl-to-memory ROM loader with byte swap and header skip
module rom_load_bridge #(
    parameter int AW        = 25,
    parameter int DW        = 16,
    parameter int DEPTH     = 4,
    parameter int HDR_BYTES = 512
) (
    input  logic           clk_sys,
    input  logic           reset,
    rom_load_bridge_if.slave bus,
    input  logic           swap_en,
    input  logic           hdr_en,
    output logic [AW-1:0]  rom_size,
    output logic           busy,
    output logic           drop_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NB = DW / 8;
    localparam logic [AW-1:0] HDR      = AW'(HDR_BYTES);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count, count_next;
    logic          dl_q, swap_l, hdr_l;
    logic          rise, swap_eff, hdr_eff, push_req, push, pop;
    logic [AW-1:0] rebased, end_addr;
    logic [DW-1:0] word;

    function automatic logic [DW-1:0] byterev(input logic [DW-1:0] d);
        for (int i = 0; i < NB; i++) byterev[8*i +: 8] = d[DW-8-8*i +: 8];
    endfunction

    // Ingress decode; modes latched at download start also apply to a write in that same cycle
    always_comb begin
        rise       = bus.ioctl_download & ~dl_q;
        swap_eff   = rise ? swap_en : swap_l;
        hdr_eff    = rise ? hdr_en : hdr_l;
        push_req   = bus.ioctl_wr & bus.ioctl_download & ~(hdr_eff & (bus.ioctl_addr < HDR));
        pop        = (state == S_IDLE) & (count != '0) & (bus.mem_we_req == bus.mem_we_ack);
        push       = push_req & ((count != FULL) | pop);
        count_next = count + CW'(push) - CW'(pop);
        rebased    = bus.ioctl_addr - (hdr_eff ? HDR : '0);
        end_addr   = rebased + AW'(NB);
        word       = swap_eff ? byterev(bus.ioctl_dout) : bus.ioctl_dout;
        busy       = bus.ioctl_download | (count != '0) | (bus.mem_we_req != bus.mem_we_ack);
    end

    // FIFO write side, occupancy, backpressure and download status tracking
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            dl_q           <= 1'b0;
            swap_l         <= 1'b0;
            hdr_l          <= 1'b0;
            rom_size       <= '0;
            drop_err       <= 1'b0;
            bus.ioctl_wait <= 1'b0;
        end else begin
            dl_q <= bus.ioctl_download;
            if (rise) begin
                swap_l <= swap_en;
                hdr_l  <= hdr_en;
            end
            if (push) begin
                fifo_addr[wp] <= rebased;
                fifo_data[wp] <= word;
                wp            <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count          <= count_next;
            bus.ioctl_wait <= count_next >= WAIT_LVL;
            rom_size       <= push && (rise || end_addr > rom_size) ? end_addr : rise ? '0 : rom_size;
            drop_err       <= (push_req & ~push) | (drop_err & ~rise);
        end
    end

    // Drain FSM: one outstanding toggle request at a time; reset abandons it by matching ack
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= S_IDLE;
            bus.mem_addr   <= '0;
            bus.mem_din    <= '0;
            bus.mem_we_req <= bus.mem_we_ack;
        end else if (pop) begin
            bus.mem_addr   <= fifo_addr[rp];
            bus.mem_din    <= fifo_data[rp];
            bus.mem_we_req <= ~bus.mem_we_req;
            state          <= S_WAIT;
        end else if (state == S_WAIT && bus.mem_we_ack == bus.mem_we_req) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_rom_load_bridge.sv
// tb_rom_load_bridge: directed scenario tests for rom_load_bridge with a toggle-ack memory model
module tb_rom_load_bridge;
    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        swap_en = 1'b0;
    logic        hdr_en  = 1'b0;
    logic [24:0] rom_size;
    logic        busy;
    logic        drop_err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int wr_cyc = 0;
    bit hold   = 1'b0;
    logic last_req;

    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;
    wr_t cap[$];

    always #5 clk_sys = ~clk_sys;

    // Posedge counter used to measure request latency
    always @(posedge clk_sys) cyc <= cyc + 1;

    rom_load_bridge_if #(.AW(25), .DW(16)) bus();

    rom_load_bridge #(.AW(25), .DW(16), .DEPTH(4), .HDR_BYTES(512)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bus      (bus),
        .swap_en  (swap_en),
        .hdr_en   (hdr_en),
        .rom_size (rom_size),
        .busy     (busy),
        .drop_err (drop_err)
    );

    // Memory model: logs every request toggle and acks it unless held off
    initial begin
        bus.mem_we_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset) last_req = bus.mem_we_req;
            else begin
                if (bus.mem_we_req !== last_req) begin
                    cap.push_back('{bus.mem_addr, bus.mem_din, cyc});
                    last_req = bus.mem_we_req;
                end
                if (!hold && bus.mem_we_req !== bus.mem_we_ack) bus.mem_we_ack = bus.mem_we_req;
            end
        end
    end

    task automatic host_write(input logic [24:0] a, input logic [15:0] d, input bit honour);
        int n = 0;
        while (honour && bus.ioctl_wait === 1'b1 && n < 300) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, required 0", bus.ioctl_wait, n);
        end
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        wr_cyc         = cyc;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input bit s, input bit h);
        swap_en            = s;
        hdr_en             = h;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 1000) begin
            n_chk++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        n_chk++; if (bus.ioctl_wait !== 1'b0) $display("FAIL rst_wait: got %b want 0", bus.ioctl_wait); else n_pass++;
        n_chk++; if (bus.mem_addr !== 25'h0) $display("FAIL rst_addr: got %h want 0", bus.mem_addr); else n_pass++;
        n_chk++; if (bus.mem_din !== 16'h0) $display("FAIL rst_din: got %h want 0", bus.mem_din); else n_pass++;
        n_chk++; if (rom_size !== 25'h0) $display("FAIL rst_size: got %h want 0", rom_size); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL rst_drop: got %b want 0", drop_err); else n_pass++;
        n_chk++; if (bus.mem_we_req !== bus.mem_we_ack) $display("FAIL rst_req: got req %b want ack %b", bus.mem_we_req, bus.mem_we_ack); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_basic();
        cap.delete();
        start_dl(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) host_write(25'(2 * i), 16'hA000 + 16'(i), 1'b1);
        bus.ioctl_download = 1'b0;
        wait_idle();
        n_chk++; if (cap.size() !== 8) $display("FAIL basic_count: got %0d want 8", cap.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (i < cap.size()) begin
                n_chk++; if (cap[i].a !== 25'(2 * i)) $display("FAIL basic_addr%0d: got %h want %h", i, cap[i].a, 25'(2 * i)); else n_pass++;
                n_chk++; if (cap[i].d !== 16'hA000 + 16'(i)) $display("FAIL basic_data%0d: got %h want %h", i, cap[i].d, 16'hA000 + 16'(i)); else n_pass++;
            end
        end
        n_chk++; if (rom_size !== 25'd16) $display("FAIL basic_size: got %0d want 16", rom_size); else n_pass++;
        n_chk++; if (drop_err !== 1'b0) $display("FAIL basic_drop: got %b want 0", drop_err); else n_pass++;
    endtask

    task automatic test_swap();
        cap.delete();
        start_dl(1'b1, 1'b0);
        host_write(25'h0, 16'h1234, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_idle();
        n_chk++; if (cap.size() !== 1) $display("FAIL swap_count: got %0d want 1", cap.size()); else n_pass++;
        if (cap.size() > 0) begin
            n_chk++; if (cap[0].d !== 16'h3412) $display("FAIL swap_data: got %h want 3412", cap[0].d); else n_pass++;
            n_chk++; if (cap[0].a !== 25'h0) $display("FAIL swap_addr: got %h want 0", cap[0].a); else n_pass++;
            n_chk++; if (cap[0].c - wr_cyc !== 2) $display("FAIL swap_latency: got %0d want 2", cap[0].c - wr_cyc); else n_pass++;
        end
        n_chk++; if (rom_size !== 25'd2) $display("FAIL swap_size: got %0d want 2", rom_size); else n_pass++;
    endtask

    task automatic test_hdr();
        cap.delete();
        start_dl(1'b0, 1'b1);
        hdr_en = 1'b0;
        for (int a = 0; a <= 'h206; a += 2) host_write(25'(a), 16'(a) ^ 16'h5A5A, 1'b1);
        bus.ioctl_download = 1'b0;
        wait_idle();
        n_chk++; if (cap.size() !== 4) $display("FAIL hdr_count: got %0d want 4", cap.size()); else n_pass++;
        if (cap.size() >= 4) begin
            n_chk++; if (cap[0].a !== 25'h0) $display("FAIL hdr_addr0: got %h want 0", cap[0].a); else n_pass++;
            n_chk++; if (cap[0].d !== 16'h585A) $display("FAIL hdr_data0: got %h want 585a", cap[0].d); else n_pass++;
            n_chk++; if (cap[3].a !== 25'h6) $display("FAIL hdr_addr3: got %h want 6", cap[3].a); else n_pass++;
            n_chk++; if (cap[3].d !== 16'h585C) $display("FAIL hdr_data3: got %h want 585c", cap[3].d); else n_pass++;
        end
        n_chk++; if (rom_size !== 25'd8) $display("FAIL hdr_size: got %0d want 8", rom_size); else n_pass++;
    endtask

    task automatic test_backpressure();
        cap.delete();
        hold = 1'b1;
        start_dl(1'b0, 1'b0);
        fork
            begin
                repeat (20) @(negedge clk_sys);
                hold = 1'b0;
            end
        join_none
        for (int i = 0; i < 4; i++) host_write(25'(2 * i), 16'hB000 + 16'(i), 1'b1);
        n_chk++; if (bus.ioctl_wait !== 1'b1) $display("FAIL bp_wait: got %b want 1", bus.ioctl_wait); else n_pass++;
        for (int i = 4; i < 6; i++) host_write(25'(2 * i), 16'hB000 + 16'(i), 1'b1);
        bus.ioctl_download = 1'b0;
        wait_idle();
        n_chk++; if (cap.size() !== 6) $display("FAIL bp_count: got %0d want 6", cap.size()); else n_pass++;
        for (int i = 0; i < 6; i++)
            if (i < cap.size()) begin
                n_chk++; if (cap[i].d !== 16'hB000 + 16'(i)) $display("FAIL bp_data%0d: got %h want %h", i, cap[i].d, 16'hB000 + 16'(i)); else n_pass++;
            end
        n_chk++; if (drop_err !== 1'b0) $display("FAIL bp_drop: got %b want 0", drop_err); else n_pass++;
        n_chk++; if (rom_size !== 25'd12) $display("FAIL bp_size: got %0d want 12", rom_size); else n_pass++;
    endtask

    task automatic test_drop();
        cap.delete();
        hold = 1'b1;
        start_dl(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) host_write(25'(2 * i), 16'hC000 + 16'(i), 1'b0);
        n_chk++; if (drop_err !== 1'b1) $display("FAIL drop_flag: got %b want 1", drop_err); else n_pass++;
        n_chk++; if (rom_size !== 25'd10) $display("FAIL drop_size: got %0d want 10", rom_size); else n_pass++;
        hold = 1'b0;
        bus.ioctl_download = 1'b0;
        wait_idle();
        n_chk++; if (cap.size() !== 5) $display("FAIL drop_count: got %0d want 5", cap.size()); else n_pass++;
        for (int i = 0; i < 5; i++)
            if (i < cap.size()) begin
                n_chk++; if (cap[i].d !== 16'hC000 + 16'(i)) $display("FAIL drop_data%0d: got %h want %h", i, cap[i].d, 16'hC000 + 16'(i)); else n_pass++;
            end
        n_chk++; if (drop_err !== 1'b1) $display("FAIL drop_sticky: got %b want 1", drop_err); else n_pass++;
        start_dl(1'b0, 1'b0);
        n_chk++; if (drop_err !== 1'b0) $display("FAIL drop_clear: got %b want 0", drop_err); else n_pass++;
        n_chk++; if (rom_size !== 25'd0) $display("FAIL size_clear: got %0d want 0", rom_size); else n_pass++;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        start_dl(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) host_write(25'(2 * i), 16'hD000 + 16'(i), 1'b1);
        bus.ioctl_download = 1'b0;
        cap.delete();
        reset = 1'b1;
        @(negedge clk_sys);
        n_chk++; if (bus.mem_we_req !== bus.mem_we_ack) $display("FAIL mid_req: got req %b want ack %b", bus.mem_we_req, bus.mem_we_ack); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (bus.ioctl_wait !== 1'b0) $display("FAIL mid_wait: got %b want 0", bus.ioctl_wait); else n_pass++;
        n_chk++; if (rom_size !== 25'd0) $display("FAIL mid_size: got %0d want 0", rom_size); else n_pass++;
        reset = 1'b0;
        hold  = 1'b0;
        repeat (20) @(negedge clk_sys);
        n_chk++; if (cap.size() !== 0) $display("FAIL mid_writes: got %0d want 0", cap.size()); else n_pass++;
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        test_reset();
        test_basic();
        test_swap();
        test_hdr();
        test_backpressure();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
